crc5_frame_ctrl: RTL and testbench
==================================

Name: crc5_frame_ctrl

Overview:
Frame sequencer that serializes a parallel data word MSB-first and appends its 5-bit CRC to the same bit stream. The CRC is polynomial 0x25 (x^5 + x^2 + 1), MSB-first, initial value 0, no output XOR. The CRC is computed by an internal instance of the team's bit-serial CRC-5 engine, which this block drives one bit per accepted output bit. It sits between a word-level producer and a bit-level serial transmitter, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 8, payload width in bits per frame (legal range 1..32)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer offers in_data
in_ready  output  1  block can accept a frame word
in_data  input  DATA_W  payload word; bit DATA_W-1 is sent first
sout_valid  output  1  sout_bit is valid
sout_ready  input  1  transmitter accepts sout_bit this cycle
sout_bit  output  1  current serial bit
sout_last  output  1  marks the final CRC bit of the frame
busy  output  1  frame in progress (state != IDLE)
done  output  1  one-cycle pulse when a frame completes
crc_value  output  5  CRC of the last completed frame; held until the next done

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, in_ready=1, sout_valid=0, sout_bit=0, sout_last=0, busy=0, done=0, crc_value=0, internal CRC=0, bit counter=0.
  - Reset mid-frame abandons the frame immediately; no done pulse; crc_value returns to 0.
- CRC update per bit b: fb = b ^ crc[4]; crc_next = {crc[3:0],0} ^ (fb ? 5'b00101 : 0).
- Output handshake: a bit transfers only on a cycle with sout_valid & sout_ready.
  - sout_bit, sout_last and sout_valid hold stable while sout_ready=0.
- States:
  - IDLE: in_ready=1, sout_valid=0.
    - On in_valid & in_ready: latch in_data into the shift register, clear the CRC to 0, set counter=DATA_W-1, go to DATA.
    - in_ready is combinational from state only; it never depends on in_valid.
  - DATA: sout_valid=1, sout_bit = shift register MSB.
    - On each transfer: CRC advances with sout_bit, shift left, counter decrements.
    - On the transfer with counter=0: load the CRC shift register with crc_next (the final payload bit included), set counter=4, go to CRC.
  - CRC: sout_valid=1, sout_bit = CRC shift register bit 4; sout_last=1 when counter=0.
    - On each transfer: shift left, counter decrements.
    - On the transfer with counter=0: crc_value <= the frame CRC, done <= 1 for the next cycle only, go to IDLE.
- Timing with sout_ready held at 1:
  - Word accepted at cycle T; first bit is valid at T+1.
  - Last CRC bit transfers at T+DATA_W+5; done=1 and in_ready=1 at T+DATA_W+6.
  - Back-to-back frames therefore have one idle cycle between them.
- in_valid is ignored while busy (in_ready=0); the producer must hold in_data until accepted.
- sout_ready may toggle arbitrarily; stalls add cycles but never change the bit sequence.
- The transmitted frame (payload followed by CRC) has CRC residual 0 under the same polynomial.

Test Plan:
- DATA_W=8, in_data=0x80, sout_ready=1 -> bits 1,0,0,0,0,0,0,0 then CRC 0,1,1,1,0; sout_last on the 13th bit; crc_value=0x0E; done pulses at accept+14.
- in_data=0x01 -> CRC bits 0,0,1,0,1; crc_value=0x05. in_data=0x00 -> CRC bits all 0; crc_value=0x00.
- in_data=0x80 with sout_ready pseudo-random (~50%) -> identical 13-bit sequence and crc_value=0x0E; outputs stable during every stall cycle.
- in_valid held high with two queued words 0x80 then 0x01 -> second word accepted exactly at the done cycle; second frame bits follow; crc_value goes 0x0E then 0x05.
- rst asserted after 5 payload bits of 0x80 -> next cycle: sout_valid=0, in_ready=1, no done pulse, crc_value=0; a following frame 0x01 produces CRC 0x05.
- Residual check: a reference CRC model fed all 13 transmitted bits of random words ends at 0; repeat over 1000 random words, including for DATA_W=1 and DATA_W=32 builds.

Source files
------------

// File: rtl/crc5_frame_ctrl.sv
// ============================================================================
// crc5_frame_ctrl : serializes a DATA_W-bit word MSB-first, then appends its
//                   CRC-5 (x^5 + x^2 + 1, init 0, no output XOR).
// Revision        : 1.0
// ============================================================================
`default_nettype none

// Bit-serial CRC-5 engine, one bit per enabled cycle.
module crc5_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [4:0] crc_o,
    output logic [4:0] crc_next_o
);
    localparam logic [4:0] C_POLY = 5'b00101;

    logic [4:0] crc_q;
    logic       fb;

    assign fb         = bit_i ^ crc_q[4];
    assign crc_next_o = {crc_q[3:0], 1'b0} ^ (fb ? C_POLY : 5'b00000);
    assign crc_o      = crc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            crc_q <= 5'b00000;
        end else if (en_i) begin
            crc_q <= crc_next_o;
        end
    end
endmodule

module crc5_frame_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sout_valid,
    input  logic              sout_ready,
    output logic              sout_bit,
    output logic              sout_last,
    output logic              busy,
    output logic              done,
    output logic [4:0]        crc_value
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [4:0]        crc_shift_q;
    logic [4:0]        cnt_q;
    logic [4:0]        crc_value_q;
    logic              done_q;

    logic              accept;
    logic              xfer;
    logic              crc_en;
    logic [4:0]        crc_cur;
    logic [4:0]        crc_d;

    assign accept = (state_q == S_IDLE) && in_valid;
    assign xfer   = sout_valid && sout_ready;
    assign crc_en = (state_q == S_DATA) && sout_ready;

    crc5_serial u_crc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .en_i       (crc_en),
        .bit_i      (shift_q[DATA_W-1]),
        .crc_o      (crc_cur),
        .crc_next_o (crc_d)
    );

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign sout_valid = (state_q == S_DATA) || (state_q == S_CRC);
    assign sout_bit   = (state_q == S_DATA) ? shift_q[DATA_W-1] :
                        (state_q == S_CRC)  ? crc_shift_q[4]    : 1'b0;
    assign sout_last  = (state_q == S_CRC) && (cnt_q == 5'd0);
    assign done       = done_q;
    assign crc_value  = crc_value_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            crc_shift_q <= 5'b00000;
            cnt_q       <= 5'd0;
            crc_value_q <= 5'b00000;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        shift_q <= in_data;
                        cnt_q   <= 5'(DATA_W - 1);
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        shift_q <= shift_q << 1;
                        if (cnt_q == 5'd0) begin
                            // crc_d already folds in the final payload bit
                            crc_shift_q <= crc_d;
                            cnt_q       <= 5'd4;
                            state_q     <= S_CRC;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (xfer) begin
                        crc_shift_q <= crc_shift_q << 1;
                        if (cnt_q == 5'd0) begin
                            crc_value_q <= crc_cur;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_crc5_frame_ctrl.sv
// ============================================================================
// tb_crc5_frame_ctrl : frame-level model bench for crc5_frame_ctrl, plus
//                      residual checks on DATA_W=1 and DATA_W=32 builds.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_crc5_frame_ctrl;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          sout_ready = 1'b1;
    logic          in_ready, sout_valid, sout_bit, sout_last, busy, done;
    logic [4:0]    crc_value;

    always #5 clk = ~clk;

    crc5_frame_ctrl #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sout_valid(sout_valid), .sout_ready(sout_ready),
        .sout_bit(sout_bit), .sout_last(sout_last), .busy(busy), .done(done),
        .crc_value(crc_value)
    );

    // Free-running builds at the width extremes
    logic        d1 = 1'b0;
    logic [31:0] d32 = 32'h0;
    logic        ir1, sv1, sb1, sl1, bz1, dn1;
    logic        ir32, sv32, sb32, sl32, bz32, dn32;
    logic [4:0]  cv1, cv32;

    crc5_frame_ctrl #(.DATA_W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(1'b1), .in_ready(ir1), .in_data(d1),
        .sout_valid(sv1), .sout_ready(1'b1), .sout_bit(sb1), .sout_last(sl1),
        .busy(bz1), .done(dn1), .crc_value(cv1)
    );

    crc5_frame_ctrl #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(1'b1), .in_ready(ir32), .in_data(d32),
        .sout_valid(sv32), .sout_ready(1'b1), .sout_bit(sb32), .sout_last(sl32),
        .busy(bz32), .done(dn32), .crc_value(cv32)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] crc_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    endfunction

    // ---------------- frame model ----------------
    typedef struct {
        logic b;
        logic last;
    } ebit_t;

    ebit_t      expq[$];
    logic [4:0] fcrcq[$];
    logic [4:0] exp_crcv = 5'h0;
    logic       exp_done = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_bit = 1'b0;
    logic       prev_last = 1'b0;
    logic [4:0] res = 5'h0;
    logic [12:0] cap = '0;
    int         tbits = 0;
    int         cyc = 0;

    always @(posedge clk) cyc++;

    task automatic push_frame(input logic [DW-1:0] d);
        logic [4:0] c;
        c = 5'h0;
        for (int i = DW - 1; i >= 0; i--) begin
            expq.push_back('{b: d[i], last: 1'b0});
            c = crc_step(c, d[i]);
        end
        for (int i = 4; i >= 0; i--)
            expq.push_back('{b: c[i], last: (i == 0)});
        fcrcq.push_back(c);
    endtask

    always @(negedge clk) begin
        ebit_t e;
        if (rst) begin
            expq.delete();
            fcrcq.delete();
            exp_crcv   = 5'h0;
            exp_done   = 1'b0;
            prev_stall = 1'b0;
            res        = 5'h0;
        end else begin
            chk("done", done, exp_done);
            chk("crc_value", crc_value, exp_crcv);
            chk("in_ready", in_ready, expq.size() == 0);
            chk("busy", busy, expq.size() != 0);
            chk("sout_valid", sout_valid, expq.size() != 0);
            if (prev_stall) begin
                chk("stall_bit", sout_bit, prev_bit);
                chk("stall_last", sout_last, prev_last);
            end
            if (expq.size() != 0) begin
                chk("sout_bit", sout_bit, expq[0].b);
                chk("sout_last", sout_last, expq[0].last);
            end
            exp_done = 1'b0;
            if (sout_valid && sout_ready && expq.size() != 0) begin
                e     = expq.pop_front();
                res   = crc_step(res, sout_bit);
                cap   = {cap[11:0], sout_bit};
                tbits++;
                if (e.last) begin
                    exp_crcv = fcrcq.pop_front();
                    exp_done = 1'b1;
                    chk("residual_w8", res, 5'h0);
                    res = 5'h0;
                end
            end
            prev_stall = sout_valid && !sout_ready;
            prev_bit   = sout_bit;
            prev_last  = sout_last;
            if (in_valid && in_ready)
                push_frame(in_data);
        end
    end

    // ---------------- residual monitors for DATA_W=1 / 32 ----------------
    logic [4:0] r1 = 5'h0;
    logic [4:0] r32 = 5'h0;
    int         n1 = 0;
    int         n32 = 0;

    always @(negedge clk) begin
        if (rst) begin
            r1  = 5'h0;
            r32 = 5'h0;
        end else begin
            if (!ir1)  d1  = 1'($urandom_range(0, 1));
            if (!ir32) d32 = $urandom;
            if (sv1) begin
                r1 = crc_step(r1, sb1);
                if (sl1) begin
                    if (n1 < 1000) chk("residual_w1", r1, 5'h0);
                    r1 = 5'h0;
                    n1++;
                end
            end
            if (sv32) begin
                r32 = crc_step(r32, sb32);
                if (sl32) begin
                    if (n32 < 1000) chk("residual_w32", r32, 5'h0);
                    r32 = 5'h0;
                    n32++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic rmode = 1'b0;

    always @(posedge clk) begin
        #1;
        sout_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int acc_cyc;
    int done_cyc;

    task automatic send(input logic [DW-1:0] d, input logic hold);
        int k;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 500);
        if (!in_ready) chk("accept_timeout", 0, 1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 500);
        if (!done) chk("done_timeout", 0, 1);
        done_cyc = cyc;
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sout_valid", sout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_crc_value", crc_value, 0);
        chk("rst_sout_bit", sout_bit, 0);
        chk("rst_sout_last", sout_last, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Hand-computed frames with sout_ready held high
        send(8'h80, 1'b0);
        wait_done();
        chk("lat_0x80", done_cyc - acc_cyc, 14);
        chk("bits_0x80", cap, 13'b1000_0000_01110);
        chk("crc_0x80", crc_value, 5'h0E);

        send(8'h01, 1'b0);
        wait_done();
        chk("bits_0x01", cap, 13'b0000_0001_00101);
        chk("crc_0x01", crc_value, 5'h05);

        send(8'h00, 1'b0);
        wait_done();
        chk("bits_0x00", cap, 13'b0);
        chk("crc_0x00", crc_value, 5'h00);

        // Random stalls on the serial side
        rmode = 1'b1;
        send(8'h80, 1'b0);
        wait_done();
        chk("bits_0x80_stall", cap, 13'b1000_0000_01110);
        chk("crc_0x80_stall", crc_value, 5'h0E);
        rmode = 1'b0;
        repeat (2) @(posedge clk);

        // Two queued words, in_valid held high
        send(8'h80, 1'b1);
        in_data = 8'h01;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 500);
        chk("q_accept_at_done", done, 1);
        chk("q_crc_first", crc_value, 5'h0E);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done();
        chk("q_crc_second", crc_value, 5'h05);

        // Reset mid-frame
        send(8'h80, 1'b0);
        k = tbits;
        while (tbits < k + 4) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_sout_valid", sout_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_done", done, 0);
        chk("mrst_crc_value", crc_value, 5'h0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("mrst_no_done", done, 0);
        end
        send(8'h01, 1'b0);
        wait_done();
        chk("mrst_crc_0x01", crc_value, 5'h05);

        // Random words with random stalls
        rmode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(8'($urandom), 1'b0);
            wait_done();
        end
        rmode = 1'b0;

        k = 0;
        while ((n1 < 1000 || n32 < 1000) && k < 60000) begin
            @(negedge clk);
            k++;
        end
        chk("w1_frames_done", n1 >= 1000, 1);
        chk("w32_frames_done", n32 >= 1000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

`default_nettype wire
